// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver: per-channel off/on/pwm/blink with period-aligned double buffering.
// Optional blink support is compiled in when LED_PWM_BANK_BLINK_EN is defined.
module led_pwm_bank #(
  parameter int CHANNELS       = 8,
  parameter int CH_W           = 3,
  parameter int PWM_W          = 8,
  parameter int BLINK_DIV      = 64,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                csi_clk,
  input  logic                rsi_reset,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_W-1:0]    wr_duty,
  output logic                period_start,
  output logic [CHANNELS-1:0] coe_led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  localparam logic             OFF_LVL = (LED_ACTIVE_LOW != 0);
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  if ((1 << CH_W) < CHANNELS) begin : g_bad_ch_w
    $error("CH_W too narrow for CHANNELS");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  logic [PWM_W-1:0]    cnt;
  logic                wrap;
  logic                blink_on;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] lit;

  mode_e            mode_p [CHANNELS];
  mode_e            mode_a [CHANNELS];
  logic [PWM_W-1:0] duty_p [CHANNELS];
  logic [PWM_W-1:0] duty_a [CHANNELS];

  assign wrap = (cnt == CNT_MAX);

  // Channel indices beyond CHANNELS never match, so out-of-range writes fall away here.
  always_comb begin
    // NOTE: assign a default before the loop so no path leaves a bit unassigned (no latch).
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en && (wr_chan == CH_W'(i));
    end
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      cnt <= '0;
      // NOTE: the setting arrays are small flops, not RAM, so they reset like any register.
      for (int i = 0; i < CHANNELS; i++) begin
        mode_p[i] <= MODE_OFF;
        mode_a[i] <= MODE_OFF;
        duty_p[i] <= '0;
        duty_a[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values of its neighbours.
      cnt <= cnt + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit[i]) begin
          mode_p[i] <= mode_e'(wr_mode);
          duty_p[i] <= wr_duty;
        end
        // A write landing on the wrap edge bypasses pending so it is not a period late.
        if (wrap) begin
          mode_a[i] <= wr_hit[i] ? mode_e'(wr_mode) : mode_p[i];
          duty_a[i] <= wr_hit[i] ? wr_duty : duty_p[i];
        end
      end
    end
  end

`ifdef LED_PWM_BANK_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // Phase moves only on the wrap edge, so a blinking channel never shows a partial period.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_on = blink_phase;
`else
  assign blink_on = 1'b1;
`endif

  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_a[i])
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = 1'b1;
        MODE_PWM:   lit[i] = (cnt < duty_a[i]);
        MODE_BLINK: lit[i] = blink_on && (cnt < duty_a[i]);
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      period_start <= 1'b0;
      coe_led      <= {CHANNELS{OFF_LVL}};
    end else begin
      period_start <= (cnt == '0);
      coe_led      <= lit ^ {CHANNELS{OFF_LVL}};
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank: an 8-channel active-low instance for the main checks
// and a 6-channel instance that only ever sees out-of-range writes.
module tb_led_pwm_bank;

  localparam int BLINK_DIV = 2;
  localparam int NO_INJ    = -1;

  logic       csi_clk   = 1'b0;
  logic       rsi_reset = 1'b0;
  logic       wr_en     = 1'b0;
  logic       wr_en6    = 1'b0;
  logic [2:0] wr_chan   = '0;
  logic [1:0] wr_mode   = '0;
  logic [7:0] wr_duty   = '0;

  logic       period_start;
  logic       period_start6;
  logic [7:0] coe_led;
  logic [5:0] coe_led6;

  int n_cmp      = 0;
  int n_bad      = 0;
  int period_idx = 0;

  always #5 csi_clk = ~csi_clk;

  led_pwm_bank #(
    .CHANNELS(8), .CH_W(3), .PWM_W(8), .BLINK_DIV(BLINK_DIV), .LED_ACTIVE_LOW(1)
  ) dut (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_mode(wr_mode), .wr_duty(wr_duty), .period_start(period_start), .coe_led(coe_led)
  );

  led_pwm_bank #(
    .CHANNELS(6), .CH_W(3), .PWM_W(8), .BLINK_DIV(BLINK_DIV), .LED_ACTIVE_LOW(1)
  ) dut6 (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset), .wr_en(wr_en6), .wr_chan(wr_chan),
    .wr_mode(wr_mode), .wr_duty(wr_duty), .period_start(period_start6), .coe_led(coe_led6)
  );

  // Called at the negedge showing slot 0; observes 256 slots and returns at the next slot 0.
  // Optionally injects one write: set at observed slot inj_k, so the DUT samples cnt = inj_k+1.
  task automatic check_period(input string tag, input int ch, input int exp_lit,
                              input logic [7:0] still_mask, input int inj_k, input bit inj6,
                              input logic [2:0] inj_ch, input logic [1:0] inj_mode,
                              input logic [7:0] inj_duty);
    int   lit_n     = 0;
    int   shape_err = 0;
    int   ps_err    = 0;
    int   mask_err  = 0;
    int   d6_err    = 0;
    logic lit;
    for (int k = 0; k < 256; k++) begin
      lit = ~coe_led[ch];
      if (lit) lit_n++;
      if (lit !== (k < exp_lit)) shape_err++;
      if (period_start !== (k == 0)) ps_err++;
      if ((coe_led & still_mask) !== still_mask) mask_err++;
      if (coe_led6 !== 6'h3F || period_start6 !== (k == 0)) d6_err++;
      wr_en  = 1'b0;
      wr_en6 = 1'b0;
      if (k == inj_k) begin
        wr_chan = inj_ch;
        wr_mode = inj_mode;
        wr_duty = inj_duty;
        if (inj6) wr_en6 = 1'b1;
        else      wr_en  = 1'b1;
      end
      @(negedge csi_clk);
    end
    wr_en  = 1'b0;
    wr_en6 = 1'b0;

    n_cmp++;
    assert (lit_n === exp_lit) else begin
      n_bad++;
      $error("FAIL %s lit_slots ch%0d: got %0d want %0d", tag, ch, lit_n, exp_lit);
    end
    n_cmp++;
    assert (shape_err === 0) else begin
      n_bad++;
      $error("FAIL %s slot_shape ch%0d: got %0d bad slots want 0", tag, ch, shape_err);
    end
    n_cmp++;
    assert (ps_err === 0) else begin
      n_bad++;
      $error("FAIL %s period_start: got %0d bad cycles want 0", tag, ps_err);
    end
    n_cmp++;
    assert (mask_err === 0) else begin
      n_bad++;
      $error("FAIL %s idle_pins mask %h: got %0d bad cycles want 0", tag, still_mask, mask_err);
    end
    n_cmp++;
    assert (d6_err === 0) else begin
      n_bad++;
      $error("FAIL %s dut6_idle: got %0d bad cycles want 0", tag, d6_err);
    end
    period_idx++;
  endtask

  initial begin
    int exp_blink;

    // Reset asserted between clock edges must force the off level at once.
    #2 rsi_reset = 1'b1;
    #1;
    n_cmp++;
    assert (coe_led === 8'hFF) else begin
      n_bad++; $error("FAIL rst_led: got %h want ff", coe_led);
    end
    n_cmp++;
    assert (period_start === 1'b0) else begin
      n_bad++; $error("FAIL rst_ps: got %b want 0", period_start);
    end
    n_cmp++;
    assert (coe_led6 === 6'h3F) else begin
      n_bad++; $error("FAIL rst_led6: got %h want 3f", coe_led6);
    end

    @(negedge csi_clk);
    rsi_reset = 1'b0;
    @(negedge csi_clk);
    n_cmp++;
    assert (period_start === 1'b1) else begin
      n_bad++; $error("FAIL first_ps: got %b want 1", period_start);
    end
    period_idx = 0;

    check_period("idle",     2, 0,   8'hFF, NO_INJ, 0, 3'd0, 2'b00, 8'd0);
    check_period("pwm_wr",   2, 0,   8'hFF, 0,      0, 3'd2, 2'b10, 8'd64);
    check_period("pwm64",    2, 64,  8'hFB, 0,      0, 3'd2, 2'b10, 8'd0);
    check_period("duty0",    2, 0,   8'hFB, 0,      0, 3'd2, 2'b10, 8'd255);
    check_period("duty255",  2, 255, 8'hFB, 0,      0, 3'd2, 2'b01, 8'd0);
    check_period("mode_on",  2, 256, 8'hFB, 0,      0, 3'd2, 2'b00, 8'd0);
    check_period("mode_off", 2, 0,   8'hFF, 0,      0, 3'd0, 2'b10, 8'd200);

    // Mid-period rewrite of ch0 must wait for the boundary.
    check_period("db_cur",   0, 200, 8'hFE, 49,     0, 3'd0, 2'b10, 8'd10);
    // Write sampled on the wrap edge (cnt = 255) must show in the very next period.
    check_period("db_next",  0, 10,  8'hFE, 254,    0, 3'd1, 2'b10, 8'd32);
    check_period("wrap_wr",  1, 32,  8'hFC, 0,      1, 3'd7, 2'b01, 8'd255);
    check_period("oor7",     1, 32,  8'hFC, 0,      1, 3'd6, 2'b01, 8'd255);
    check_period("oor6",     0, 10,  8'hFC, 0,      0, 3'd3, 2'b11, 8'd128);

    for (int p = 0; p < 5; p++) begin
`ifdef LED_PWM_BANK_BLINK_EN
      exp_blink = (((period_idx / BLINK_DIV) % 2) == 1) ? 128 : 0;
`else
      exp_blink = 128;
`endif
      check_period("blink", 3, exp_blink, 8'hF4, NO_INJ, 0, 3'd0, 2'b00, 8'd0);
    end

    // Abort a live period with lit channels; everything must fall back to off.
    #2 rsi_reset = 1'b1;
    #1;
    n_cmp++;
    assert (coe_led === 8'hFF) else begin
      n_bad++; $error("FAIL midrst_led: got %h want ff", coe_led);
    end
    n_cmp++;
    assert (period_start === 1'b0) else begin
      n_bad++; $error("FAIL midrst_ps: got %b want 0", period_start);
    end
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    @(negedge csi_clk);
    n_cmp++;
    assert (period_start === 1'b1) else begin
      n_bad++; $error("FAIL midrst_first_ps: got %b want 1", period_start);
    end
    period_idx = 0;

    check_period("post_rst_ch1", 1, 0, 8'hFF, NO_INJ, 0, 3'd0, 2'b00, 8'd0);
    check_period("post_rst_ch3", 3, 0, 8'hFF, NO_INJ, 0, 3'd0, 2'b00, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_bank.md
# led_pwm_bank

Multi-channel LED driver for the POV display's Qsys LED path. It holds a per-channel mode and an 8-bit-class duty value written over a simple strobe interface, and drives `CHANNELS` registered LED pins with glitch-free PWM, static on/off or dimmed blink. Writes are double-buffered so a channel's new setting takes effect only at a PWM period boundary. The block sits between the register-slave front end and the conduit pins, replacing the single-LED latch.

## Interface
- `CHANNELS`, 8: number of LED outputs.
- `CH_W`, 3: width of channel select; must satisfy 2^CH_W >= CHANNELS.
- `PWM_W`, 4..16, default 8: PWM counter and duty width; the period is 2^PWM_W clocks.
- `BLINK_DIV`, 64: number of PWM periods per blink half-cycle; must be >= 1.
- `LED_ACTIVE_LOW`, 1: 1 = pin low lights the LED; 0 = pin high lights the LED.

- `csi_clk`  in  1  sole clock.
- `rsi_reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  one-cycle write strobe.
- `wr_chan`  in  CH_W  target channel; values >= CHANNELS are ignored.
- `wr_mode`  in  2  00 off, 01 on, 10 pwm, 11 blink.
- `wr_duty`  in  PWM_W  on-slots per period.
- `period_start`  out  1  registered pulse aligned with output slot 0.
- `coe_led`  out  CHANNELS  registered LED pins.

## Operation
- **PWM counter:** `cnt` (PWM_W bits) increments every clock and wraps from 2^PWM_W−1 to 0.
- **Per-channel registers:** each channel has pending registers (`mode_p`, `duty_p`) and active registers (`mode_a`, `duty_a`).
- **Write:** when `wr_en`=1 and `wr_chan` < CHANNELS, the pending registers of that channel load `wr_mode`/`wr_duty` at the clock edge.
  - Writes to other channels are unaffected.
  - Out-of-range writes change no state.
- **Transfer:** on the edge where `cnt` wraps (max→0), every channel's active registers load their pending registers.
  - If a valid write to channel i occurs on that same edge, channel i's active registers load the write data directly. The write is not lost and not delayed a period.
- **Lit condition, per channel i (evaluated with current `cnt`):**
  - Off: never lit.
  - On: always lit.
  - Pwm: lit when `cnt` < `duty_a`. Duty 0 means never lit; duty 2^PWM_W−1 means lit 255/256 of slots at PWM_W=8.
  - Blink: lit when `blink_phase`=1 and `cnt` < `duty_a`.
- **Blink divider:** `blink_cnt` counts wraps of `cnt` from 0 to BLINK_DIV−1. On the wrap where `blink_cnt`=BLINK_DIV−1, `blink_cnt` returns to 0 and `blink_phase` toggles. Width is clog2(BLINK_DIV), minimum 1.
- **Pin polarity:** `coe_led[i]` = lit XOR `LED_ACTIVE_LOW`, registered.
- **Reset (async, while `rsi_reset`=1):**
  - `cnt`, `blink_cnt`, `blink_phase`, all duty registers = 0.
  - All modes = off.
  - `period_start` = 0.
  - `coe_led` = all off level: all 1s if LED_ACTIVE_LOW, else all 0s.
- **Reset mid-period:** reset aborts the period immediately. After release, the counter restarts at 0 and outputs stay off until channels are written and a period boundary passes.

## Timing
- Output latency is 1 clock: `coe_led` after the edge that samples `cnt`=k reflects slot k.
- `period_start` = 1 for exactly the one cycle in which `coe_led` shows slot 0; it is 0 in all other cycles. First assertion occurs 1 clock after reset release.
- A write accepted during period P affects outputs from the first slot-0 output of period P+1.
  - Exception: a write on the wrap edge itself takes effect in slot 0 immediately following.
- Back-to-back writes to the same channel within a period: the last one wins.
- `blink_phase` changes only at period boundaries, so there is no partial-period glitch.

## Configuration
- `LED_PWM_BANK_BLINK_EN` defined: blink divider and mode 11 are implemented as above.
- Not defined: `blink_cnt`/`blink_phase` are not synthesised, and mode 11 behaves identically to mode 10 (pwm).

## Test plan
- **Reset values:** CHANNELS=8, PWM_W=8, LED_ACTIVE_LOW=1. Assert `rsi_reset` asynchronously mid-clock → `coe_led`=8'hFF and `period_start`=0 immediately. Release → `period_start` pulses every 256 clocks, and `coe_led` stays 8'hFF.
- **PWM duty:** write ch2 mode 10 duty 64 → from the next `period_start` onward, `coe_led[2]`=0 for 64 cycles then 1 for 192 cycles per period; other bits stay 1.
- **Boundary duties and static modes:**
  - Duty 0 → ch2 never lit.
  - Duty 255 → ch2 lit 255 of 256 cycles.
  - Mode 01 → `coe_led[2]` held 0.
  - Mode 00 → held 1.
- **Double buffering:** with ch0 pwm duty 200 active, write ch0 duty 10 at `cnt`=50 → the current period still shows 200 lit slots, and the next period shows 10.
- **Write on wrap edge and out-of-range channel:**
  - Write ch1 duty 32 on the edge `cnt` 255→0 → the very next period shows 32 lit slots.
  - Write `wr_chan`=7 with CHANNELS=6 → no output or state change.
- **Blink (macro defined):** BLINK_DIV=2, ch3 mode 11 duty 128 → ch3 shows 2 periods with 128 lit slots, then 2 dark periods, repeating. With the macro undefined, the same write → 128 lit slots every period.
